alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_seq_pkg.sv | 24 ++
 rtl/pb_edge.sv | 25 ++
 rtl/alu_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and defaults for the button-driven ALU sequencer.
// State encoding is fixed at 3 bits so it can be shown directly on the state port.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    ST_ENTER_A  = 3'd0,
    ST_ENTER_B  = 3'd1,
    ST_ENTER_OP = 3'd2,
    ST_EXEC     = 3'd3,
    ST_SHOW     = 3'd4
  } state_t;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_OPW     = 3;
  localparam int DEF_TIMEOUT = 200;

  localparam logic ERR_NONE    = 1'b0;
  localparam logic ERR_TIMEOUT = 1'b1;

  function automatic logic is_entry(input state_t s);
    return (s == ST_ENTER_A) || (s == ST_ENTER_B) || (s == ST_ENTER_OP);
  endfunction

endpackage

// File: rtl/pb_edge.sv
// Rising-edge pulse from a raw button level; pulse is combinational from the level, one cycle wide.
// Disarmed for the first cycle after reset so a button held through reset needs a fresh 0->1 to fire.
module pb_edge (
  input  logic clk_i,
  input  logic reset_i,
  input  logic level_i,
  output logic pulse_o
);

  logic prev_q;
  logic armed_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= level_i;
      armed_q <= 1'b1;
    end
  end

  assign pulse_o = armed_q & ~prev_q & level_i;

endmodule

// File: rtl/alu_sequencer.sv
// Collects operand A, operand B and opcode bit-serially from buttons, fires the ALU and shows the result.
// alu_start is a registered one-cycle pulse; EXEC waits up to TIMEOUT cycles for alu_done.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int OPW     = DEF_OPW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             hz100,
  input  logic             reset,
  input  logic             pb_zero,
  input  logic             pb_one,
  input  logic             pb_next,
  input  logic             pb_clear,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_done,
  output logic [WIDTH-1:0] opa,
  output logic [WIDTH-1:0] opb,
  output logic [OPW-1:0]   op,
  output logic             alu_start,
  output logic [WIDTH-1:0] disp,
  output logic [2:0]       state,
  output logic             err
);

  localparam int              CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic zero_p, one_p, next_p, clr_p;

  pb_edge u_pb_zero  (.clk_i(hz100), .reset_i(reset), .level_i(pb_zero),  .pulse_o(zero_p));
  pb_edge u_pb_one   (.clk_i(hz100), .reset_i(reset), .level_i(pb_one),   .pulse_o(one_p));
  pb_edge u_pb_next  (.clk_i(hz100), .reset_i(reset), .level_i(pb_next),  .pulse_o(next_p));
  pb_edge u_pb_clear (.clk_i(hz100), .reset_i(reset), .level_i(pb_clear), .pulse_o(clr_p));

  state_t           state_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opa_q, opb_q, res_q;
  logic [OPW-1:0]   op_q;
  logic             err_q;
  logic             start_q;
  logic [CNT_W-1:0] cnt_q;

  // Coincident zero/one pulses cancel and leave acc untouched.
  always_comb begin
    acc_d = acc_q;
    if (zero_p ^ one_p) begin
      acc_d = {acc_q[WIDTH-2:0], one_p};
    end
  end

  always_ff @(posedge hz100) begin
    if (reset) begin
      state_q <= ST_ENTER_A;
      acc_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      op_q    <= '0;
      res_q   <= '0;
      err_q   <= ERR_NONE;
      start_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      start_q <= 1'b0;
      if (clr_p) begin
        state_q <= ST_ENTER_A;
        acc_q   <= '0;
        opa_q   <= '0;
        opb_q   <= '0;
        op_q    <= '0;
        res_q   <= '0;
        err_q   <= ERR_NONE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          ST_ENTER_A: begin
            if (next_p) begin
              opa_q   <= acc_q;
              acc_q   <= '0;
              state_q <= ST_ENTER_B;
            end else begin
              acc_q <= acc_d;
            end
          end
          ST_ENTER_B: begin
            if (next_p) begin
              opb_q   <= acc_q;
              acc_q   <= '0;
              state_q <= ST_ENTER_OP;
            end else begin
              acc_q <= acc_d;
            end
          end
          ST_ENTER_OP: begin
            if (next_p) begin
              op_q    <= acc_q[OPW-1:0];
              acc_q   <= '0;
              start_q <= 1'b1;
              cnt_q   <= '0;
              state_q <= ST_EXEC;
            end else begin
              acc_q <= acc_d;
            end
          end
          ST_EXEC: begin
            // alu_done is checked first so it wins over the final timeout cycle.
            if (alu_done) begin
              res_q   <= alu_result;
              err_q   <= ERR_NONE;
              state_q <= ST_SHOW;
            end else if (cnt_q == CNT_LAST) begin
              res_q   <= '0;
              err_q   <= ERR_TIMEOUT;
              state_q <= ST_SHOW;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          ST_SHOW: begin
            if (next_p) begin
              acc_q   <= '0;
              state_q <= ST_ENTER_A;
            end
          end
          default: state_q <= ST_ENTER_A;
        endcase
      end
    end
  end

  always_comb begin
    disp = '0;
    if (is_entry(state_q)) begin
      disp = acc_q;
    end else if (state_q == ST_SHOW) begin
      disp = res_q;
    end
  end

  assign opa       = opa_q;
  assign opb       = opb_q;
  assign op        = op_q;
  assign alu_start = start_q;
  assign err       = err_q;
  assign state     = state_q;

endmodule
